// File: rtl/vga_text_pkg.sv
// Shared constants, cell-address helper and FSM state type for the text renderer.
package vga_text_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned GLYPH_W  = 8;
  localparam int unsigned GLYPH_H  = 8;
  localparam int unsigned CELLS    = 4800;
  localparam int unsigned ADDR_W   = 13;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // row*80 + col using two shifts and adds instead of a multiplier
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col, input logic [5:0] row);
    logic [ADDR_W-1:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4) + {6'd0, col};
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// 1024 x 8 synchronous glyph ROM addressed by {char, line}; bit 7 is the leftmost pixel.
// Built-in minimal font: 'A' is drawn, codes up to space are blank, every other code
// renders as a hollow box so unknown characters remain visible.
module glyph_rom (
  input  logic       clk,
  input  logic [9:0] addr,
  output logic [7:0] data
);

  logic [6:0] code;
  logic [2:0] line;
  logic [7:0] row_bits;

  assign code = addr[9:3];
  assign line = addr[2:0];

  // Font lookup
  always_comb begin
    row_bits = 8'h00;
    if (code == 7'h41) begin
      unique case (line)
        3'd0:    row_bits = 8'h18;
        3'd1:    row_bits = 8'h3c;
        3'd2:    row_bits = 8'h66;
        3'd3:    row_bits = 8'h66;
        3'd4:    row_bits = 8'h7e;
        3'd5:    row_bits = 8'h66;
        3'd6:    row_bits = 8'h66;
        default: row_bits = 8'h00;
      endcase
    end else if (code > 7'h20) begin
      row_bits = (line == 3'd0 || line == 3'd7) ? 8'hff : 8'h81;
    end
  end

  // Registered ROM output
  always_ff @(posedge clk) begin
    data <= row_bits;
  end

endmodule

// File: rtl/text_glyph_renderer.sv
// 80x60 text-mode pixel source: text RAM -> glyph ROM -> RGB, 3-cycle aligned with syncs/de.
module text_glyph_renderer
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 60,
  parameter logic [6:0]  CLEAR_CHAR  = 7'h20,
  parameter logic [2:0]  CLEAR_COLOR = 3'b111,
  parameter int unsigned BLINK_LOG2  = 5,
  parameter logic        SYNC_IDLE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [2:0] pixel,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_col,
  input  logic [5:0] wr_row,
  input  logic [6:0] wr_char,
  input  logic [2:0] wr_color,
  input  logic       clear_req,
  output logic       busy,
  input  logic       cursor_en,
  input  logic [6:0] cursor_col,
  input  logic [5:0] cursor_row
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [9:0]        mem_wdata;
  logic [9:0]        mem [CELLS];

  logic [BLINK_LOG2-1:0] blink_q;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  hit0;

  logic [9:0] cell1;
  logic [2:0] line1, idx1, idx2;
  logic       hit1, hit2, de1, de2, hs1, hs2, vs1, vs2;
  logic [2:0] color2;
  logic [7:0] glyph2;

  // FSM state register; reset always (re)starts a clear from address 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // FSM next state: clear_req only matters in idle, clear walks every cell once
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
          state_d    = StIdle;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // FSM outputs and shared RAM write port; out-of-range host writes complete but do nothing
  always_comb begin
    wr_ready  = 1'b0;
    busy      = 1'b1;
    mem_we    = 1'b0;
    mem_waddr = clr_addr_q;
    mem_wdata = {CLEAR_COLOR, CLEAR_CHAR};
    unique case (state_q)
      StIdle: begin
        wr_ready  = 1'b1;
        busy      = 1'b0;
        mem_waddr = cell_addr(wr_col, wr_row);
        mem_wdata = {wr_color, wr_char};
        mem_we    = wr_valid && !clear_req && (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
      end
      StClear: mem_we = 1'b1;
      default: ;
    endcase
  end

  // Text RAM write port
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_addr = cell_addr(x[9:3], y[8:3]);
  assign hit0    = cursor_en && (x[9:3] == cursor_col) && (y[8:3] == cursor_row) &&
                   (y[2:0] == 3'd7) && blink_q[BLINK_LOG2-1];

  // Frame counter for the cursor blink, stepped at the start of vertical blanking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else if (x == 10'd0 && y == 9'(V_ACTIVE)) begin
      blink_q <= blink_q + 1'b1;
    end
  end

  // S1 text RAM read; addresses past the last cell (blanking) read as zero
  always_ff @(posedge clk) begin
    cell1 <= (32'(rd_addr) < CELLS) ? mem[rd_addr] : 10'd0;
  end

  glyph_rom u_glyph_rom (
    .clk  (clk),
    .addr ({cell1[6:0], line1}),
    .data (glyph2)
  );

  // S1/S2 delay line for position, cursor, colour and timing signals
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line1  <= '0;
      idx1   <= '0;
      hit1   <= 1'b0;
      de1    <= 1'b0;
      hs1    <= SYNC_IDLE;
      vs1    <= SYNC_IDLE;
      idx2   <= '0;
      hit2   <= 1'b0;
      color2 <= '0;
      de2    <= 1'b0;
      hs2    <= SYNC_IDLE;
      vs2    <= SYNC_IDLE;
    end else begin
      line1  <= y[2:0];
      idx1   <= x[2:0];
      hit1   <= hit0;
      de1    <= de_in;
      hs1    <= hsync_in;
      vs1    <= vsync_in;
      idx2   <= idx1;
      hit2   <= hit1;
      color2 <= cell1[9:7];
      de2    <= de1;
      hs2    <= hs1;
      vs2    <= vs1;
    end
  end

  // S3 pixel select, blanked whenever the aligned display-enable is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel     <= '0;
      de_out    <= 1'b0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      pixel     <= (de2 && (glyph2[3'd7 - idx2] || hit2)) ? color2 : 3'b000;
      de_out    <= de2;
      hsync_out <= hs2;
      vsync_out <= vs2;
    end
  end

endmodule

// File: tb/tb_text_glyph_renderer.sv
// Directed self-checking bench for text_glyph_renderer.
module tb_text_glyph_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x;
  logic [8:0] y;
  logic       de_in, hsync_in, vsync_in;
  logic [2:0] pixel;
  logic       de_out, hsync_out, vsync_out;
  logic       wr_valid, wr_ready;
  logic [6:0] wr_col, wr_char;
  logic [5:0] wr_row;
  logic [2:0] wr_color;
  logic       clear_req, busy;
  logic       cursor_en;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;

  int n_tests = 0;
  int n_fail  = 0;

  always #20 clk = ~clk;

  text_glyph_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .de_in      (de_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pixel      (pixel),
    .de_out     (de_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_col     (wr_col),
    .wr_row     (wr_row),
    .wr_char    (wr_char),
    .wr_color   (wr_color),
    .clear_req  (clear_req),
    .busy       (busy),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    x        = 10'd700;
    y        = 9'd500;
    de_in    = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
  endtask

  // Drive 8 consecutive pixels and capture the outputs that belong to each, 3 edges later
  task automatic sweep(input logic [9:0] x0, input logic [8:0] yy, input logic [7:0] de_pat,
                       input logic [7:0] hs_pat, input logic [7:0] vs_pat,
                       output logic [23:0] pix, output logic [7:0] de_o,
                       output logic [7:0] hs_o, output logic [7:0] vs_o);
    pix = '0; de_o = '0; hs_o = '0; vs_o = '0;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        x        = x0 + 10'(c);
        y        = yy;
        de_in    = de_pat[c];
        hsync_in = hs_pat[c];
        vsync_in = vs_pat[c];
      end else begin
        idle_inputs();
      end
      tick();
      if (c >= 2) begin
        pix[(c-2)*3 +: 3] = pixel;
        de_o[c-2]         = de_out;
        hs_o[c-2]         = hsync_out;
        vs_o[c-2]         = vsync_out;
      end
    end
  endtask

  task automatic host_write(input logic [6:0] col, input logic [5:0] row,
                            input logic [6:0] ch, input logic [2:0] color, output bit ok);
    wr_col = col; wr_row = row; wr_char = ch; wr_color = color; wr_valid = 1'b1;
    for (int i = 0; i < 10000 && !wr_ready; i++) tick();
    ok = wr_ready;
    tick();
    wr_valid = 1'b0;
  endtask

  // Count consecutive busy samples, starting with the one already seen high
  task automatic count_busy(input int pulse_at, output int cnt);
    cnt = 1;
    for (int i = 0; i < 10000; i++) begin
      clear_req = (cnt == pulse_at);
      tick();
      if (busy) cnt++;
      else break;
    end
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] pix;
    logic [7:0]  d, h, v;
    int          cnt;
    rst_n = 1'b0; idle_inputs();
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0; wr_color = '0;
    clear_req = 1'b0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    tick(); tick(); tick();
    n_tests++; if (pixel !== 3'd0)   begin n_fail++; $display("FAIL reset_pixel got %0d want 0", pixel); end
    n_tests++; if (de_out !== 1'b0)  begin n_fail++; $display("FAIL reset_de got %0b want 0", de_out); end
    n_tests++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %0b want 1", hsync_out); end
    n_tests++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %0b want 1", vsync_out); end
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", wr_ready); end
    n_tests++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL reset_busy got %0b want 1", busy); end
    rst_n = 1'b1;
    count_busy(-1, cnt);
    n_tests++; if (cnt != 4800) begin n_fail++; $display("FAIL reset_clear_len got %0d want 4800", cnt); end
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %0b want 1", wr_ready); end
    sweep(10'd0, 9'd0, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL reset_blank_cell got %h want 0", pix); end
    sweep(10'd632, 9'd475, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL reset_blank_last got %h want 0", pix); end
  endtask

  task automatic test_write_glyph();
    logic [23:0] pix;
    logic [7:0]  d, h, v;
    logic [7:0]  rows [3];
    logic [8:0]  lines [3];
    logic [2:0]  want;
    bit          ok;
    rows  = '{8'h18, 8'h66, 8'h7e};
    lines = '{9'd0, 9'd2, 9'd4};
    host_write(7'd0, 6'd0, 7'h41, 3'b100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL write_A_accept got 0 want 1"); end
    for (int r = 0; r < 3; r++) begin
      sweep(10'd0, lines[r], 8'hff, 8'hff, 8'hff, pix, d, h, v);
      for (int i = 0; i < 8; i++) begin
        want = rows[r][7-i] ? 3'b100 : 3'b000;
        n_tests++;
        if (pix[i*3 +: 3] !== want) begin
          n_fail++;
          $display("FAIL write_A line %0d x %0d got %0d want %0d", lines[r], i, pix[i*3 +: 3], want);
        end
      end
    end
  endtask

  task automatic test_sync_de();
    logic [23:0] pix;
    logic [7:0]  d, h, v;
    logic [2:0]  want [8];
    want = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0};
    // de low at x=3 (a lit pixel of 'A') must blank it; hsync low for x=2..4
    sweep(10'd0, 9'd0, 8'b1101_0111, 8'b1110_0011, 8'b0111_1110, pix, d, h, v);
    n_tests++; if (d !== 8'b1101_0111) begin n_fail++; $display("FAIL sync_de got %b want 11010111", d); end
    n_tests++; if (h !== 8'b1110_0011) begin n_fail++; $display("FAIL sync_hs got %b want 11100011", h); end
    n_tests++; if (v !== 8'b0111_1110) begin n_fail++; $display("FAIL sync_vs got %b want 01111110", v); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (pix[i*3 +: 3] !== want[i]) begin
        n_fail++;
        $display("FAIL sync_pixel x %0d got %0d want %0d", i, pix[i*3 +: 3], want[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [23:0] pix;
    logic [7:0]  d, h, v;
    wr_col = 7'd80; wr_row = 6'd5; wr_char = 7'h41; wr_color = 3'b001; wr_valid = 1'b1;
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready_col got %0b want 1", wr_ready); end
    tick();
    wr_col = 7'd3; wr_row = 6'd60;
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready_row got %0b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    sweep(10'd632, 9'd40, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL oor_cell_79_5 got %h want 0", pix); end
    sweep(10'd0, 9'd48, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL oor_cell_0_6 got %h want 0", pix); end
    sweep(10'd24, 9'd472, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL oor_cell_3_59 got %h want 0", pix); end
  endtask

  task automatic test_clear();
    logic [23:0] pix;
    logic [7:0]  d, h, v;
    int          cnt;
    wr_col = 7'd5; wr_row = 6'd0; wr_char = 7'h41; wr_color = 3'b001;
    wr_valid = 1'b1; clear_req = 1'b1;
    tick();
    wr_valid = 1'b0; clear_req = 1'b0;
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready_drop got %0b want 0", wr_ready); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy got %0b want 1", busy); end
    count_busy(100, cnt);
    n_tests++; if (cnt != 4800) begin n_fail++; $display("FAIL clear_len got %0d want 4800", cnt); end
    sweep(10'd0, 9'd0, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL clear_wiped_A got %h want 0", pix); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (2000) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_rst_busy got %0b want 1", busy); end
    count_busy(-1, cnt);
    n_tests++; if (cnt != 4800) begin n_fail++; $display("FAIL clear_restart_len got %0d want 4800", cnt); end
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready_after got %0b want 1", wr_ready); end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      x = 10'd0; y = 9'd480; de_in = 1'b0;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_cursor();
    logic [23:0] pix;
    logic [7:0]  d, h, v;
    bit          ok;
    host_write(7'd10, 6'd20, 7'h41, 3'b010, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cursor_write got 0 want 1"); end
    cursor_en = 1'b1; cursor_col = 7'd10; cursor_row = 6'd20;
    sweep(10'd80, 9'd167, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL cursor_frame0 got %h want 0", pix); end
    frames(16);
    sweep(10'd80, 9'd167, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'o22222222) begin n_fail++; $display("FAIL cursor_frame16 got %h want 492492", pix); end
    sweep(10'd88, 9'd167, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL cursor_neighbour got %h want 0", pix); end
    sweep(10'd80, 9'd166, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'o02200220) begin n_fail++; $display("FAIL cursor_line6 got %h want 090090", pix); end
    cursor_en = 1'b0;
    sweep(10'd80, 9'd167, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL cursor_disabled got %h want 0", pix); end
    cursor_en = 1'b1;
    frames(15);
    sweep(10'd80, 9'd167, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'o22222222) begin n_fail++; $display("FAIL cursor_frame31 got %h want 492492", pix); end
    frames(1);
    sweep(10'd80, 9'd167, 8'hff, 8'hff, 8'hff, pix, d, h, v);
    n_tests++; if (pix !== 24'd0) begin n_fail++; $display("FAIL cursor_frame32 got %h want 0", pix); end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_glyph();
    test_sync_de();
    test_out_of_range();
    test_clear();
    test_cursor();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_glyph_renderer.md
Name: text_glyph_renderer

Overview:
Text-mode pixel source for the 640x480 VGA path. It sits between hvsync_generator and the pixel output register. It maps the current beam position (CounterX/CounterY) to an 80x60 grid of 8x8 character cells, reads a text RAM and then a glyph ROM, and emits a 3-bit RGB pixel. Syncs and display-enable are delayed by the same number of cycles so they stay aligned with the pixel. A host write port, a clear-screen engine and a blinking underline cursor let other logic draw text.

Parameters:
COLS, 80, characters per row (640/8)
ROWS, 60, character rows (480/8)
CLEAR_CHAR, 7'h20, code written by the clear engine (space)
CLEAR_COLOR, 3'b111, colour written by the clear engine
BLINK_LOG2, 5, cursor blink period is 2^BLINK_LOG2 frames (half on, half off)
SYNC_IDLE, 1'b1, reset value of hsync_out/vsync_out

Ports:
clk  in  1  25 MHz pixel clock
rst_n  in  1  synchronous, active-low reset
x  in  10  beam column (CounterX)
y  in  9  beam line (CounterY)
de_in  in  1  inDisplayArea from the sync generator
hsync_in  in  1  raw hsync
vsync_in  in  1  raw vsync
pixel  out  3  RGB, aligned with de_out
de_out  out  1  de_in delayed by 3 cycles
hsync_out  out  1  hsync_in delayed by 3 cycles
vsync_out  out  1  vsync_in delayed by 3 cycles
wr_valid  in  1  host write request
wr_ready  out  1  high when a write can be accepted
wr_col  in  7  target column
wr_row  in  6  target row
wr_char  in  7  character code
wr_color  in  3  foreground RGB
clear_req  in  1  one-cycle pulse that starts a clear-screen
busy  out  1  high while the clear engine runs
cursor_en  in  1  enable the cursor
cursor_col  in  7  cursor column
cursor_row  in  6  cursor row

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low.
- Reset values: pixel=0, de_out=0, hsync_out=vsync_out=SYNC_IDLE, wr_ready=0, busy=1, blink counter=0, FSM enters CLEAR at address 0.
- Address mapping: column=x[9:3], row=y[8:3], glyph line=y[2:0], bit index=x[2:0]. Cell address = row*80+col, 13 bits, computed as (row<<6)+(row<<4)+col. No multiplier.
- Text RAM: 4800 x 10 bits, stored as {color[2:0], char[6:0]}. Simple dual port: synchronous read port for the display, write port shared by host and clear engine. There is never a read/write conflict.
- Pipeline, fixed latency 3 cycles from x/y/de_in/syncs to outputs:
  - S1: register the RAM read using the cell address; delay line, bit index and cursor-match.
  - S2: glyph_rom read at {char, line}; delay colour and bit index.
  - S3: pixel = (glyph bit[7-idx] | cursor_hit) ? color : 0, gated to 0 when the delayed de is low.
- cursor_hit = cursor_en && cell==(cursor_col,cursor_row) && line==7 && blink[BLINK_LOG2-1].
- Blink counter increments once per frame, on the cycle where x==0 and y==480. It wraps modulo 2^BLINK_LOG2.
- FSM states:
  - IDLE: wr_ready=1, busy=0.
  - CLEAR: wr_ready=0, busy=1; writes {CLEAR_COLOR, CLEAR_CHAR} to address 0..4799, one per cycle, then returns to IDLE. Takes exactly 4800 cycles.
- Transitions:
  - IDLE -> CLEAR on clear_req. No host write is accepted in that cycle.
  - clear_req while in CLEAR is ignored; the clear does not restart.
  - Reset mid-clear restarts the clear from address 0.
- Write handshake: a write is accepted on the edge where wr_valid && wr_ready. The RAM is updated on that edge and is visible to a display read starting the following cycle.
- Out-of-range writes (wr_col>=80 or wr_row>=60) are accepted (handshake completes) but discarded.
- Display reads are unaffected by host writes except through the updated data.
- Outside the active area (x>=640 or y>=480) the RAM address is don't-care. The output is forced to 0 via de.

Decomposition:
- Package vga_text_pkg:
  - constants H_ACTIVE=640, V_ACTIVE=480, GLYPH_W=8, GLYPH_H=8, CELLS=4800, ADDR_W=13;
  - cell-address function;
  - FSM state enum {IDLE, CLEAR}.
- One sub-module, glyph_rom: 1024 x 8 synchronous ROM, addressed by {char[6:0], line[2:0]}, initialised from a font file; MSB is the leftmost pixel.

Test Plan:
- Reset, then hold: busy=1 and wr_ready=0 for exactly 4800 cycles, then busy=0 and wr_ready=1. Every visible pixel is 0 (space glyph is blank).
- Write char 'A' (7'h41) at col 0, row 0, colour 3'b100. At x=0..7, y=0, pixel equals 3'b100 where ROM[0x41*8+0] bits are set, else 0, appearing 3 cycles after each x.
- Drive a hsync_in low pulse and de_in toggles: hsync_out and de_out replicate them exactly 3 cycles later. pixel=0 whenever de_out=0, even over a non-blank cell.
- Write at col 80, row 5, then at col 3, row 60: both handshakes complete with wr_ready high. RAM is unchanged and cells 79/5 and 3/59 still render blank.
- Pulse clear_req with wr_valid=1: that write is not accepted, wr_ready drops next cycle, the clear runs 4800 cycles, and a second clear_req at cycle 100 does not extend it. Assert rst_n low mid-clear: the clear restarts and lasts another 4800 cycles.
- cursor_en=1 at (10,20), BLINK_LOG2=5: line y=167, x=80..87 shows the cell colour during frames 16..31 of each 32-frame period and the glyph only during frames 0..15.
